i2c_reg_sequencer: RTL and testbench

Transaction-level sequencer that drives the byte-level command strobes of `i2c_core` to perform complete single-byte register writes and reads on a 7-bit I2C device. It accepts one request at a time over a valid/ready handshake and issues START, address, register, data, repeated-START and STOP steps in order. It reports read data and an error code on a one-cycle response pulse. It sits between a requester (CPU-facing wrapper or autonomous init engine) and `i2c_core`, in place of software poking the control register byte by byte.

---
 rtl/i2c_seq_pkg.sv | 37 +++
 rtl/i2c_seq_timeout.sv | 54 +++++
 rtl/i2c_reg_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared constants for the I2C register sequencer: FSM state encoding,
// response error codes and the R/W bit values appended to the 7-bit device
// address. Imported by i2c_reg_sequencer and i2c_seq_timeout.
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

   // FSM state encoding. All step states sit in one contiguous range
   // (ST_START..ST_STOP) so that isStepState can be a range check.
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_START  = 4'd1;
   localparam logic [3:0] ST_ADDR_W = 4'd2;
   localparam logic [3:0] ST_REG    = 4'd3;
   localparam logic [3:0] ST_DATA_W = 4'd4;
   localparam logic [3:0] ST_RSTART = 4'd5;
   localparam logic [3:0] ST_ADDR_R = 4'd6;
   localparam logic [3:0] ST_RD     = 4'd7;
   localparam logic [3:0] ST_STOP   = 4'd8;
   localparam logic [3:0] ST_RESP   = 4'd9;

   // Response error codes
   localparam logic [1:0] ERR_OK        = 2'd0;
   localparam logic [1:0] ERR_ADDR_NACK = 2'd1;
   localparam logic [1:0] ERR_DATA_NACK = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

   // R/W bit in the address byte (also the meaning of req_rw)
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // True for every state that issues a strobe and then waits for a done pulse
   function automatic logic isStepState(input logic [3:0] st);
      return (st != ST_IDLE) && (st <= ST_STOP);
   endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// ---------------------------------------------------------------------------
// i2c_seq_timeout
// Per-step watchdog for the I2C register sequencer. Only instantiated when
// the sequencer is built with I2C_SEQ_TIMEOUT_EN defined.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   load_i     reload the counter with TIMEOUT_CYCLES (strobe issue cycle)
//   dec_i      count down one cycle (wait phase)
//   expired_o  the counter reaches zero in this wait cycle
// The counter holds its value whenever neither load_i nor dec_i is high.
// ---------------------------------------------------------------------------
module i2c_seq_timeout
   import i2c_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
)(
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic dec_i,
   output logic expired_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] count_q;
   logic [CntW-1:0] count_d;

   // Reload on every strobe, count down while waiting, saturate at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LoadVal;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is flagged in the wait cycle that takes the count to zero, so
   // with a limit of N the FSM leaves the step after exactly N wait cycles.
   assign expired_o = dec_i && (count_q <= CntW'(1));

endmodule

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
// Drives the byte-level command strobes of i2c_core to perform complete
// single-byte register writes and reads on a 7-bit I2C device. One request
// is accepted at a time; the result comes back on a one-cycle response pulse.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid / req_ready        request handshake (ready only in IDLE)
//   req_rw, req_dev, req_reg,
//   req_wdata                    request fields, captured on acceptance
//   rsp_valid, rsp_rdata,
//   rsp_err                      one-cycle response (0 OK, 1 addr NACK,
//                                2 reg/data NACK, 3 timeout)
//   core_start, core_stop,
//   core_write, core_read_ack,
//   core_read_nack, core_txdata  command strobes and byte to i2c_core
//   core_rxdata, core_ack_fail,
//   core_*_done                  status and completion pulses from i2c_core
//
// Build option: define I2C_SEQ_TIMEOUT_EN to add a per-step watchdog of
// TIMEOUT_CYCLES clock cycles. Without it the FSM waits indefinitely.
// ---------------------------------------------------------------------------
module i2c_reg_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic       core_start,
   output logic       core_stop,
   output logic       core_write,
   output logic       core_read_ack,
   output logic       core_read_nack,
   output logic [7:0] core_txdata,
   input  logic [7:0] core_rxdata,
   input  logic       core_ack_fail,
   input  logic       core_rx_done,
   input  logic       core_tx_done,
   input  logic       core_start_done,
   input  logic       core_stop_done
);

   logic [3:0] state_q,     state_d;
   logic       waitPhase_q, waitPhase_d;
   logic [7:0] txData_q,    txData_d;
   logic [7:0] rdata_q,     rdata_d;
   logic [1:0] err_q,       err_d;

   logic       reqRw_q;
   logic [6:0] reqDev_q;
   logic [7:0] reqReg_q;
   logic [7:0] reqWdata_q;

   logic accept;
   logic issueCycle;
   logic waitCycle;
   logic stepDone;
   logic timeoutExpired;

   assign req_ready  = (state_q == ST_IDLE);
   assign accept     = req_valid && req_ready;
   assign issueCycle = isStepState(state_q) && !waitPhase_q;
   assign waitCycle  = isStepState(state_q) &&  waitPhase_q;

   // Strobes are decoded from the registered state, so each one is high for
   // exactly the single issue cycle of its step and drops to 0 on reset.
   assign core_start     = issueCycle && ((state_q == ST_START) || (state_q == ST_RSTART));
   assign core_write     = issueCycle && ((state_q == ST_ADDR_W) || (state_q == ST_REG) ||
                                          (state_q == ST_DATA_W) || (state_q == ST_ADDR_R));
   assign core_read_nack = issueCycle && (state_q == ST_RD);
   assign core_stop      = issueCycle && (state_q == ST_STOP);
   assign core_read_ack  = 1'b0;
   assign core_txdata    = txData_q;

   // Response fields are forced to 0 outside RESP; read data only shows for
   // a read that completed without error.
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = rsp_valid ? err_q : ERR_OK;
   assign rsp_rdata = (rsp_valid && (err_q == ERR_OK)) ? rdata_q : 8'h00;

   // Only the completion pulse belonging to the current step is listened to;
   // anything else the core reports is ignored.
   always_comb begin
      stepDone = 1'b0;
      case (state_q)
         ST_START, ST_RSTART:                     stepDone = core_start_done;
         ST_ADDR_W, ST_REG, ST_DATA_W, ST_ADDR_R: stepDone = core_tx_done;
         ST_RD:                                   stepDone = core_rx_done;
         ST_STOP:                                 stepDone = core_stop_done;
         default:                                 stepDone = 1'b0;
      endcase
   end

`ifdef I2C_SEQ_TIMEOUT_EN
   i2c_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) uTimeout (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (issueCycle),
      .dec_i     (waitCycle),
      .expired_o (timeoutExpired)
   );
`else
   assign timeoutExpired = 1'b0;
   // The limit has no effect in this build; this empty branch is the only
   // place it is referenced.
   if (TIMEOUT_CYCLES == 0) begin : gNoWatchdog
   end
`endif

   // Step sequencing. Each step spends one issue cycle (strobe high) and then
   // waits for its done pulse; the next step's byte is loaded into txData on
   // the same edge that enters its issue cycle. A NACK diverts to STOP, a
   // watchdog expiry goes straight to RESP without a STOP.
   always_comb begin
      state_d     = state_q;
      waitPhase_d = waitPhase_q;
      txData_d    = txData_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d     = ST_START;
               waitPhase_d = 1'b0;
               err_d       = ERR_OK;
               rdata_d     = 8'h00;
            end
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            txData_d = 8'h00;
         end
         ST_START, ST_ADDR_W, ST_REG, ST_DATA_W, ST_RSTART, ST_ADDR_R, ST_RD, ST_STOP: begin
            if (!waitPhase_q) begin
               waitPhase_d = 1'b1;
            end else if (stepDone) begin
               waitPhase_d = 1'b0;
               case (state_q)
                  ST_START: begin
                     state_d  = ST_ADDR_W;
                     txData_d = {reqDev_q, RW_WRITE};
                  end
                  ST_ADDR_W: begin
                     if (core_ack_fail) begin
                        err_d   = ERR_ADDR_NACK;
                        state_d = ST_STOP;
                     end else begin
                        state_d  = ST_REG;
                        txData_d = reqReg_q;
                     end
                  end
                  ST_REG: begin
                     if (core_ack_fail) begin
                        err_d   = ERR_DATA_NACK;
                        state_d = ST_STOP;
                     end else if (reqRw_q == RW_READ) begin
                        state_d = ST_RSTART;
                     end else begin
                        state_d  = ST_DATA_W;
                        txData_d = reqWdata_q;
                     end
                  end
                  ST_DATA_W: begin
                     if (core_ack_fail) begin
                        err_d = ERR_DATA_NACK;
                     end
                     state_d = ST_STOP;
                  end
                  ST_RSTART: begin
                     state_d  = ST_ADDR_R;
                     txData_d = {reqDev_q, RW_READ};
                  end
                  ST_ADDR_R: begin
                     if (core_ack_fail) begin
                        err_d   = ERR_ADDR_NACK;
                        state_d = ST_STOP;
                     end else begin
                        state_d = ST_RD;
                     end
                  end
                  ST_RD: begin
                     rdata_d = core_rxdata;
                     state_d = ST_STOP;
                  end
                  ST_STOP: begin
                     state_d = ST_RESP;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else if (timeoutExpired) begin
               waitPhase_d = 1'b0;
               err_d       = ERR_TIMEOUT;
               state_d     = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            waitPhase_d = 1'b0;
            txData_d    = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         waitPhase_q <= 1'b0;
         txData_q    <= 8'h00;
         rdata_q     <= 8'h00;
         err_q       <= ERR_OK;
      end else begin
         state_q     <= state_d;
         waitPhase_q <= waitPhase_d;
         txData_q    <= txData_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   // Request fields are frozen at acceptance so the requester may change the
   // inputs freely while the transaction runs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reqRw_q    <= RW_WRITE;
         reqDev_q   <= 7'h00;
         reqReg_q   <= 8'h00;
         reqWdata_q <= 8'h00;
      end else if (accept) begin
         reqRw_q    <= req_rw;
         reqDev_q   <= req_dev;
         reqReg_q   <= req_reg;
         reqWdata_q <= req_wdata;
      end
   end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
// Scoreboard bench for i2c_reg_sequencer. A behavioural i2c_core model
// answers each strobe with its done pulse one cycle later (zero-delay core),
// with knobs to NACK a chosen byte, delay a chosen byte's tx_done by a cycle
// while firing a stray rx_done, and never answer START (watchdog build).
// Expected strobes/responses and response latencies are queued when a
// request is accepted and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

   logic       clk;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [6:0] req_dev;
   logic [7:0] req_reg;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic       core_start;
   logic       core_stop;
   logic       core_write;
   logic       core_read_ack;
   logic       core_read_nack;
   logic [7:0] core_txdata;
   logic [7:0] core_rxdata;
   logic       core_ack_fail;
   logic       core_rx_done;
   logic       core_tx_done;
   logic       core_start_done;
   logic       core_stop_done;

   i2c_reg_sequencer #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rw          (req_rw),
      .req_dev         (req_dev),
      .req_reg         (req_reg),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .core_start      (core_start),
      .core_stop       (core_stop),
      .core_write      (core_write),
      .core_read_ack   (core_read_ack),
      .core_read_nack  (core_read_nack),
      .core_txdata     (core_txdata),
      .core_rxdata     (core_rxdata),
      .core_ack_fail   (core_ack_fail),
      .core_rx_done    (core_rx_done),
      .core_tx_done    (core_tx_done),
      .core_start_done (core_start_done),
      .core_stop_done  (core_stop_done)
   );

   localparam logic [24:0] RESET_PATTERN = 25'h100_0000;

   int compared   = 0;
   int mismatched = 0;
   int cycleCount = 0;
   int acceptCycle = 0;
   int rspCycle   = 0;
   int expSteps;
   int expExtra;

   logic [15:0] expQ[$];
   int          latQ[$];
   logic [15:0] obsEv;
   logic [15:0] expEv;
   int          expLat;

   // core model knobs
   bit       nackEn    = 1'b0;
   logic [7:0] nackByte = 8'h00;
   bit       slowEn    = 1'b0;
   logic [7:0] slowByte = 8'h00;
   bit       muteStart = 1'b0;
   logic [7:0] rxValue  = 8'h00;

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycleCount);
      end
   endtask

   // Event word: [15:10] one-hot {rsp, start, stop, write, read_ack, read_nack},
   // [9:8] error code, [7:0] byte
   function automatic logic [15:0] evStart();
      return {6'b010000, 10'h000};
   endfunction
   function automatic logic [15:0] evStop();
      return {6'b001000, 10'h000};
   endfunction
   function automatic logic [15:0] evWrite(input logic [7:0] b);
      return {6'b000100, 2'b00, b};
   endfunction
   function automatic logic [15:0] evRnack();
      return {6'b000001, 10'h000};
   endfunction
   function automatic logic [15:0] evRsp(input logic [1:0] e, input logic [7:0] d);
      return {6'b100000, e, d};
   endfunction

   function automatic logic [15:0] observedEvent();
      logic [5:0] k;
      logic [1:0] e;
      logic [7:0] d;
      k = {rsp_valid, core_start, core_stop, core_write, core_read_ack, core_read_nack};
      e = rsp_valid ? rsp_err : 2'b00;
      d = rsp_valid ? rsp_rdata : (core_write ? core_txdata : 8'h00);
      return {k, e, d};
   endfunction

   function automatic logic [24:0] packOutputs();
      return {req_ready, rsp_valid, rsp_err, rsp_rdata, core_start, core_stop,
              core_write, core_read_ack, core_read_nack, core_txdata};
   endfunction

   // Queues one expected write byte; returns whether the core model NACKs it
   function automatic bit addWrite(input logic [7:0] b);
      expQ.push_back(evWrite(b));
      expSteps++;
      if (slowEn && (b == slowByte)) expExtra++;
      return nackEn && (b == nackByte);
   endfunction

   // Reference transaction model: builds the strobe sequence, response and
   // acceptance-to-response latency (2 cycles per step + 1, plus model delays)
   task automatic pushExpected(input logic rw, input logic [6:0] dev, input logic [7:0] regA,
                               input logic [7:0] wdata, input logic [7:0] rxByte);
      logic [1:0] err;
      logic [7:0] rd;
      err = 2'd0;
      rd  = 8'h00;
      expSteps = 0;
      expExtra = 0;
      expQ.push_back(evStart());
      expSteps++;
      if (muteStart) begin
         expQ.push_back(evRsp(2'd3, 8'h00));
         latQ.push_back(18);
         return;
      end
      if (addWrite({dev, 1'b0})) err = 2'd1;
      else if (addWrite(regA)) err = 2'd2;
      else if (rw == 1'b0) begin
         if (addWrite(wdata)) err = 2'd2;
      end else begin
         expQ.push_back(evStart());
         expSteps++;
         if (addWrite({dev, 1'b1})) err = 2'd1;
         else begin
            expQ.push_back(evRnack());
            expSteps++;
            rd = rxByte;
         end
      end
      expQ.push_back(evStop());
      expSteps++;
      expQ.push_back(evRsp(err, rd));
      latQ.push_back(2 * expSteps + 1 + expExtra);
   endtask

   task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] regA,
                                input logic [7:0] wdata, input logic [7:0] rxByte,
                                output int acceptedAt);
      bit accepted;
      accepted   = 1'b0;
      acceptedAt = -1;
      @(negedge clk);
      req_rw    = rw;
      req_dev   = dev;
      req_reg   = regA;
      req_wdata = wdata;
      rxValue   = rxByte;
      req_valid = 1'b1;
      for (int i = 0; i < 100 && !accepted; i++) begin
         if (req_ready) begin
            accepted    = 1'b1;
            acceptCycle = cycleCount;
            acceptedAt  = cycleCount;
            pushExpected(rw, dev, regA, wdata, rxByte);
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      if (!accepted) checkOutput("accept wait", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      // Scramble the request inputs; the captured copy must be used
      req_valid = 1'b0;
      req_rw    = ~rw;
      req_dev   = 7'($urandom());
      req_reg   = 8'($urandom());
      req_wdata = 8'($urandom());
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
      checkOutput("queue drained", 32'(expQ.size()), 32'd0);
      @(negedge clk);
   endtask

   // Behavioural i2c_core: samples strobes mid-cycle, answers one cycle later
   initial begin
      logic pStart, pStop, pTx, pRx;
      logic [7:0] txByte;
      core_rxdata     = 8'h00;
      core_ack_fail   = 1'b0;
      core_rx_done    = 1'b0;
      core_tx_done    = 1'b0;
      core_start_done = 1'b0;
      core_stop_done  = 1'b0;
      forever begin
         @(negedge clk);
         pStart = core_start && !muteStart;
         pStop  = core_stop;
         pTx    = core_write;
         pRx    = core_read_nack;
         txByte = core_txdata;
         @(posedge clk);
         #1;
         if (pTx && slowEn && (txByte == slowByte)) begin
            core_start_done = 1'b0;
            core_stop_done  = 1'b0;
            core_tx_done    = 1'b0;
            core_ack_fail   = 1'b0;
            core_rx_done    = 1'b1;
            @(posedge clk);
            #1;
         end
         core_start_done = pStart;
         core_stop_done  = pStop;
         core_tx_done    = pTx;
         core_ack_fail   = pTx && nackEn && (txByte == nackByte);
         core_rx_done    = pRx;
         core_rxdata     = pRx ? rxValue : 8'hEE;
      end
   end

   // Scoreboard monitor: every cycle with any strobe or response is an event
   always @(negedge clk) begin
      if (reset_n) begin
         obsEv = observedEvent();
         if (obsEv != 16'h0000) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected event", 32'(obsEv), 32'd0);
            end else begin
               expEv = expQ.pop_front();
               checkOutput("event", 32'(obsEv), 32'(expEv));
            end
            if (rsp_valid) begin
               rspCycle = cycleCount;
               if (latQ.size() != 0) begin
                  expLat = latQ.pop_front();
                  checkOutput("latency", 32'(cycleCount - acceptCycle), 32'(expLat));
               end
            end
         end
      end
   end

   initial begin
      int accA, accB;
      bit found;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_dev   = 7'h00;
      req_reg   = 8'h00;
      req_wdata = 8'h00;
      #12;
      checkOutput("reset outputs", 32'(packOutputs()), 32'(RESET_PATTERN));
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] register write");
      applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, accA);
      waitDrain();

      $display("[TB] register read");
      applyStimulus(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, accA);
      waitDrain();

      $display("[TB] address NACK on write");
      nackEn = 1'b1; nackByte = 8'hA0;
      applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, accA);
      waitDrain();

      $display("[TB] address NACK after repeated start");
      nackByte = 8'h67;
      applyStimulus(1'b1, 7'h33, 8'h44, 8'h00, 8'h99, accA);
      waitDrain();

      $display("[TB] data NACK with stray rx_done in REG wait");
      nackByte = 8'h77; slowEn = 1'b1; slowByte = 8'h11;
      applyStimulus(1'b0, 7'h50, 8'h11, 8'h77, 8'h00, accA);
      waitDrain();
      nackEn = 1'b0; slowEn = 1'b0;

      $display("[TB] reset during ADDR_R wait");
      applyStimulus(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, accA);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (core_write && (core_txdata == 8'hA1)) found = 1'b1;
      end
      checkOutput("reached ADDR_R", {31'b0, found}, 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("mid-transaction reset outputs", 32'(packOutputs()), 32'(RESET_PATTERN));
      expQ.delete();
      latQ.delete();
      repeat (2) @(negedge clk);
      checkOutput("outputs held in reset", 32'(packOutputs()), 32'(RESET_PATTERN));
      reset_n = 1'b1;

      $display("[TB] back-to-back requests");
      applyStimulus(1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, accA);
      applyStimulus(1'b1, 7'h01, 8'h80, 8'h00, 8'h5A, accB);
      checkOutput("second accept offset", 32'(accB - accA), 32'd12);
      checkOutput("second accept after rsp", 32'(accB), 32'(rspCycle + 1));
      waitDrain();

`ifdef I2C_SEQ_TIMEOUT_EN
      $display("[TB] watchdog on missing start_done");
      muteStart = 1'b1;
      applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, accA);
      waitDrain();
      muteStart = 1'b0;
`endif

      checkOutput("final queue empty", 32'(expQ.size() + latQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
